// File: rtl/harmonic_scheduler.sv
// Per-sample sequencer for the shared harmonic multiply-accumulate adder: clears, walks
// harmonic indices, launches the adder per non-zero multiple and emits a saturated mix.
module harmonic_scheduler #(
    parameter int unsigned MAX_HARMONICS = 64,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned OUT_SHIFT     = 4,
    parameter int unsigned DONE_TIMEOUT  = 15,
    localparam int unsigned IW = $clog2(MAX_HARMONICS)
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_Sample_Tick,
    input  logic [IW:0]        i_Harmonic_Count,
    output logic [IW-1:0]      o_Harm_Index,
    output logic               o_Fetch,
    input  logic signed [15:0] i_Multiple,
    output logic               o_Adder_Clear,
    output logic               o_Adder_Start,
    input  logic               i_Adder_Done,
    input  logic signed [31:0] i_Accumulator,
    output logic signed [15:0] o_Mix,
    output logic               o_Mix_Valid,
    output logic               o_Busy,
    output logic               o_Overrun,
    output logic               o_Timeout
);

    localparam int unsigned     TW         = $clog2(DONE_TIMEOUT + 1);
    localparam logic [IW:0]     MAX_COUNT  = (IW + 1)'(MAX_HARMONICS);
    localparam logic [2:0]      LAT_LAST   = 3'(READ_LATENCY - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        WAIT_DATA,
        START,
        GUARD,
        WAIT_DONE,
        OUTPUT
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      index_q, index_d;
    logic [IW:0]        count_q, count_d;
    logic               empty_q, empty_d;
    logic [2:0]         lat_q, lat_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic signed [15:0] mix_q, mix_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;
    logic               fetch, adder_clear, adder_start;
    logic               last_harm;
    logic signed [31:0] acc_shifted;
    logic signed [15:0] mix_sat;

    assign last_harm   = ({1'b0, index_q} == (count_q - 1'b1));
    assign acc_shifted = i_Accumulator >>> OUT_SHIFT;

    always_comb begin
        if (acc_shifted > 32'sd32767) begin
            mix_sat = 16'sh7FFF;
        end else if (acc_shifted < -32'sd32768) begin
            mix_sat = 16'sh8000;
        end else begin
            mix_sat = acc_shifted[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        count_d     = count_q;
        empty_d     = empty_q;
        lat_d       = lat_q;
        timer_d     = timer_q;
        mix_d       = mix_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q | (i_Sample_Tick && (state_q != IDLE));
        fetch       = 1'b0;
        adder_clear = 1'b0;
        adder_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_Sample_Tick) begin
                    index_d = '0;
                    if (i_Harmonic_Count == '0) begin
                        empty_d = 1'b1;
                        count_d = '0;
                        state_d = OUTPUT;
                    end else begin
                        empty_d = 1'b0;
                        count_d = (i_Harmonic_Count > MAX_COUNT) ? MAX_COUNT : i_Harmonic_Count;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                adder_clear = 1'b1;
                state_d     = FETCH;
            end
            FETCH: begin
                fetch   = 1'b1;
                lat_d   = '0;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (lat_q == LAT_LAST) begin
                    state_d = START;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            START: begin
                // A zero multiple contributes nothing, so the adder is not started.
                if (i_Multiple == 16'sd0) begin
                    if (last_harm) begin
                        state_d = OUTPUT;
                    end else begin
                        index_d = index_q + IW'(1);
                        state_d = FETCH;
                    end
                end else begin
                    adder_start = 1'b1;
                    state_d     = GUARD;
                end
            end
            GUARD: begin
                timer_d = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_Adder_Done) begin
                    if (last_harm) begin
                        state_d = OUTPUT;
                    end else begin
                        index_d = index_q + IW'(1);
                        state_d = FETCH;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d   = 1'b1;
                    adder_clear = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            OUTPUT: begin
                mix_d   = empty_q ? 16'sd0 : mix_sat;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            count_q   <= '0;
            empty_q   <= 1'b0;
            lat_q     <= '0;
            timer_q   <= '0;
            mix_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            lat_q     <= lat_d;
            timer_q   <= timer_d;
            mix_q     <= mix_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_Harm_Index  = index_q;
    assign o_Fetch       = fetch;
    assign o_Adder_Clear = adder_clear;
    assign o_Adder_Start = adder_start;
    assign o_Mix         = mix_q;
    assign o_Mix_Valid   = valid_q;
    assign o_Busy        = (state_q != IDLE);
    assign o_Overrun     = overrun_q;
    assign o_Timeout     = timeout_q;

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Directed bench for harmonic_scheduler with a one-cycle-latency RAM stub and a MAC adder stub.
module tb_harmonic_scheduler;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tick = 1'b0;
    logic [6:0]         hcount = '0;
    logic [5:0]         harm_index;
    logic               fetch;
    logic signed [15:0] mult_q = '0;
    logic signed [15:0] samp_q = '0;
    logic               adder_clear;
    logic               adder_start;
    logic               done = 1'b1;
    logic               pend = 1'b0;
    logic signed [31:0] acc = '0;
    logic signed [15:0] mix;
    logic               mix_valid;
    logic               busy;
    logic               overrun;
    logic               timeout;

    logic signed [15:0] mult_tab [64];
    logic signed [15:0] samp_tab [64];
    logic               stuck = 1'b0;
    logic               ovr_en = 1'b0;
    logic signed [31:0] ovr_val = '0;
    logic signed [31:0] prod;

    int total = 0;
    int bad = 0;
    int n_fetch = 0;
    int n_start = 0;
    int n_valid = 0;
    int last_idx = 0;

    always #5 clk = ~clk;

    harmonic_scheduler dut (
        .i_Clock          (clk),
        .i_Reset_n        (rst_n),
        .i_Sample_Tick    (tick),
        .i_Harmonic_Count (hcount),
        .o_Harm_Index     (harm_index),
        .o_Fetch          (fetch),
        .i_Multiple       (mult_q),
        .o_Adder_Clear    (adder_clear),
        .o_Adder_Start    (adder_start),
        .i_Adder_Done     (done),
        .i_Accumulator    (acc),
        .o_Mix            (mix),
        .o_Mix_Valid      (mix_valid),
        .o_Busy           (busy),
        .o_Overrun        (overrun),
        .o_Timeout        (timeout)
    );

    // Wavetable/multiple RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (fetch) begin
            mult_q <= mult_tab[harm_index];
            samp_q <= samp_tab[harm_index];
        end
    end

    assign prod = samp_q * mult_q;

    // Adder stub: drops done after start, accumulates (sample*multiple)>>>9 one cycle later.
    always @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            done <= 1'b1;
            pend <= 1'b0;
        end else begin
            if (adder_clear) acc <= '0;
            if (adder_start) begin
                done <= 1'b0;
                pend <= 1'b1;
            end else if (pend && !stuck) begin
                acc  <= ovr_en ? ovr_val : acc + (prod >>> 9);
                done <= 1'b1;
                pend <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (fetch) begin
            n_fetch  <= n_fetch + 1;
            last_idx <= int'(harm_index);
        end
        if (adder_start) n_start <= n_start + 1;
        if (mix_valid) n_valid <= n_valid + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < 64; i++) begin
            mult_tab[i] = '0;
            samp_tab[i] = '0;
        end
    endtask

    task automatic set_entry(input int idx, input int m, input int s);
        mult_tab[idx] = 16'(m);
        samp_tab[idx] = 16'(s);
    endtask

    // Ticks once (plus an optional second tick at cycle t2) and waits for o_Mix_Valid.
    task automatic run_sample(input int cnt, input int budget, input int t2, output int lat);
        hcount = 7'(cnt);
        tick   = 1'b1;
        step();
        tick = 1'b0;
        lat  = -1;
        for (int c = 1; c <= budget; c++) begin
            if (mix_valid) begin
                lat = c;
                break;
            end
            tick = (c == t2);
            step();
        end
        tick = 1'b0;
        step();
        step();
    endtask

    initial begin
        int lat, f0, s0, v0, cyc;

        clear_tabs();
        repeat (3) step();
        check("rst_busy", int'(busy), 0);
        check("rst_mix", int'(mix), 0);
        check("rst_valid", int'(mix_valid), 0);
        check("rst_index", int'(harm_index), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        step();

        // Three harmonics: 500 - 2000 + 1000 = -500, >>>4 = -32
        set_entry(0, 256, 1000);
        set_entry(1, 512, -2000);
        set_entry(2, 128, 4000);
        f0 = n_fetch; s0 = n_start; v0 = n_valid;
        run_sample(3, 60, 0, lat);
        check("c3_lat", lat, 18);
        check("c3_mix", int'(mix), -32);
        check("c3_valid_once", n_valid - v0, 1);
        check("c3_fetches", n_fetch - f0, 3);
        check("c3_starts", n_start - s0, 3);
        check("c3_idle", int'(busy), 0);
        check("c3_valid_low", int'(mix_valid), 0);
        check("c3_overrun", int'(overrun), 0);

        // Zero multiple skips the adder: only 320 accumulates, >>>4 = 20
        clear_tabs();
        set_entry(0, 0, 1600);
        set_entry(1, 512, 320);
        f0 = n_fetch; s0 = n_start;
        run_sample(2, 60, 0, lat);
        check("skip_lat", lat, 11);
        check("skip_mix", int'(mix), 20);
        check("skip_fetches", n_fetch - f0, 2);
        check("skip_starts", n_start - s0, 1);

        // Count zero: mix 0 two cycles after tick, no RAM or adder traffic
        f0 = n_fetch; s0 = n_start; v0 = n_valid;
        run_sample(0, 20, 0, lat);
        check("zero_lat", lat, 2);
        check("zero_mix", int'(mix), 0);
        check("zero_fetches", n_fetch - f0, 0);
        check("zero_starts", n_start - s0, 0);
        check("zero_valid_once", n_valid - v0, 1);

        // Saturation at both rails
        clear_tabs();
        set_entry(0, 512, 1);
        ovr_en  = 1'b1;
        ovr_val = 32'h7FFF_0000;
        run_sample(1, 40, 0, lat);
        check("satp_lat", lat, 8);
        check("satp_mix", int'(mix), 32767);
        ovr_val = 32'h8000_0000;
        run_sample(1, 40, 0, lat);
        check("satn_mix", int'(mix), -32768);
        ovr_en = 1'b0;

        // Count above MAX_HARMONICS clamps to 64 harmonics (indices 0..63)
        clear_tabs();
        set_entry(63, 512, 1600);
        f0 = n_fetch; s0 = n_start;
        run_sample(100, 400, 0, lat);
        check("clamp_done", int'(lat > 0), 1);
        check("clamp_mix", int'(mix), 100);
        check("clamp_fetches", n_fetch - f0, 64);
        check("clamp_last_idx", last_idx, 63);
        check("clamp_starts", n_start - s0, 1);

        // Second tick while busy: overrun set, sum and timing unaffected
        clear_tabs();
        for (int k = 0; k < 8; k++) set_entry(k, 512, 100 * (k + 1));
        v0 = n_valid;
        run_sample(8, 100, 4, lat);
        check("ovr_lat", lat, 43);
        check("ovr_mix", int'(mix), 225);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_valid_once", n_valid - v0, 1);

        // Reset mid-sum with a coincident tick
        clear_tabs();
        set_entry(0, 256, 1000);
        set_entry(1, 512, -2000);
        set_entry(2, 128, 4000);
        hcount = 7'd3;
        tick   = 1'b1;
        step();
        tick = 1'b0;
        repeat (6) step();
        check("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        tick  = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        check("mrst_busy", int'(busy), 0);
        check("mrst_mix", int'(mix), 0);
        check("mrst_overrun", int'(overrun), 0);
        check("mrst_index", int'(harm_index), 0);
        check("mrst_strobes", int'({fetch, adder_clear, adder_start, mix_valid}), 0);
        rst_n = 1'b1;
        step();
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_overrun", int'(overrun), 0);
        run_sample(3, 60, 0, lat);
        check("post_rst_lat", lat, 18);
        check("post_rst_mix", int'(mix), -32);

        // Adder never reports done: abort after 15 cycles in WAIT_DONE
        clear_tabs();
        set_entry(0, 512, 100);
        stuck  = 1'b1;
        v0     = n_valid;
        hcount = 7'd1;
        tick   = 1'b1;
        step();
        tick = 1'b0;
        cyc  = -1;
        for (int c = 0; c < 20; c++) begin
            if (adder_start) begin
                cyc = 0;
                break;
            end
            step();
        end
        check("to_started", int'(cyc == 0), 1);
        for (int c = 0; c < 40; c++) begin
            step();
            cyc++;
            if (adder_clear) break;
        end
        check("to_clear_delay", cyc, 16);
        check("to_flag_before", int'(timeout), 0);
        step();
        check("to_flag", int'(timeout), 1);
        check("to_idle", int'(busy), 0);
        repeat (3) step();
        check("to_no_valid", n_valid - v0, 0);
        stuck = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
